// File: rtl/bcd_display_counter_pkg.sv
// bcd_seg_pkg: shared BCD digit/segment widths, segment codes and decode helper
package bcd_seg_pkg;
   localparam int BCD_W = 4;
   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Active-high gfedcba code; out-of-range digits fall back to the "0" glyph
   function automatic logic [SEG_W-1:0] seg_code(input logic [BCD_W-1:0] d);
      case (d)
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_0;
      endcase
   endfunction
endpackage

// File: rtl/bcd_display_counter_if.sv
// bcd_display_counter_if: control inputs and display outputs of the BCD counter
interface bcd_display_counter_if #(parameter int DIGITS = 4) ();
   logic                en;
   logic                up;
   logic                load;
   logic [4*DIGITS-1:0] load_val;
   logic [4*DIGITS-1:0] count;
   logic [7*DIGITS-1:0] HEX;
   logic                carry;
   logic                borrow;
   logic                zero;
   modport master (output en, up, load, load_val, input count, HEX, carry, borrow, zero);
   modport slave  (input en, up, load, load_val, output count, HEX, carry, borrow, zero);
endinterface

// File: rtl/bcd_display_counter_seg7.sv
// seg7_digit: combinational BCD to active-low seven-segment decode with blanking
module seg7_digit
   import bcd_seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   input  logic             blank_i,
   output logic [SEG_W-1:0] seg_o
);
   assign seg_o = ~(blank_i ? SEG_BLANK : seg_code(bcd_i));
endmodule

// File: rtl/bcd_display_counter.sv
// bcd_display_counter: cascaded up/down BCD counter with registered 7-seg output
module bcd_display_counter
   import bcd_seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic clk,
   input  logic reset,
   bcd_display_counter_if.slave bus
);
   localparam int CW = BCD_W * DIGITS;
   localparam int HW = SEG_W * DIGITS;

   logic [CW-1:0] count_q, count_d;
   logic [HW-1:0] hex_q, hex_d, hex_rst;
   logic          carry_q, carry_d, borrow_q, borrow_d;
   logic [DIGITS:0] all9, all0, zsuf;

   // Prefix terms for the ripple enables and suffix terms for zero blanking
   always_comb begin
      all9[0] = 1'b1;
      all0[0] = 1'b1;
      zsuf[DIGITS] = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         all9[k+1] = all9[k] && (count_q[BCD_W*k +: BCD_W] == 4'd9);
         all0[k+1] = all0[k] && (count_q[BCD_W*k +: BCD_W] == 4'd0);
      end
      for (int k = DIGITS - 1; k >= 0; k--)
         zsuf[k] = zsuf[k+1] && (count_q[BCD_W*k +: BCD_W] == 4'd0);
   end

   // Next count: load (with >9 digits coerced to 0) beats a step; wraps raise carry/borrow
   always_comb begin
      count_d = count_q;
      for (int k = 0; k < DIGITS; k++)
         count_d[BCD_W*k +: BCD_W] =
            bus.load ? ((bus.load_val[BCD_W*k +: BCD_W] > 4'd9) ? 4'd0 : bus.load_val[BCD_W*k +: BCD_W]) :
            !bus.en  ? count_q[BCD_W*k +: BCD_W] :
            bus.up   ? (!all9[k] ? count_q[BCD_W*k +: BCD_W] :
                        (count_q[BCD_W*k +: BCD_W] == 4'd9) ? 4'd0 : count_q[BCD_W*k +: BCD_W] + 4'd1) :
                       (!all0[k] ? count_q[BCD_W*k +: BCD_W] :
                        (count_q[BCD_W*k +: BCD_W] == 4'd0) ? 4'd9 : count_q[BCD_W*k +: BCD_W] - 4'd1);
      carry_d  = !bus.load && bus.en && bus.up && all9[DIGITS];
      borrow_d = !bus.load && bus.en && !bus.up && all0[DIGITS];
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seg7_digit u_seg (
         .bcd_i   (count_q[BCD_W*g +: BCD_W]),
         .blank_i ((BLANK_LZ != 0) && (g > 0) && zsuf[g]),
         .seg_o   (hex_d[SEG_W*g +: SEG_W])
      );
      assign hex_rst[SEG_W*g +: SEG_W] = ((BLANK_LZ != 0) && (g > 0)) ? ~SEG_BLANK : ~SEG_0;
   end

   // State update; HEX takes its zero-count image on reset so it has no extra lag
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         hex_q    <= hex_rst;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         hex_q    <= hex_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.HEX    = hex_q;
   assign bus.carry  = carry_q;
   assign bus.borrow = borrow_q;
   assign bus.zero   = (count_q == '0);
endmodule
